// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: legal op codes, FSM encodings and
// op classification helpers.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: is_legal_op = 1'b1;
         default:                                       is_legal_op = 1'b0;
      endcase
   endfunction

   // Only arithmetic ops can report a meaningful overflow.
   function automatic logic has_ovf(input logic [3:0] op);
      has_ovf = (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle for the ALU arbiter: two request channels, the external ALU
// port and the shared response channel.
interface alu_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OPW-1:0]   req0_op;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OPW-1:0]   req1_op;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_control;
   logic [WIDTH-1:0] alu_result;
   logic             alu_overflow;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_overflow;
   logic             rsp_err;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output alu_a, alu_b, alu_control,
      input  alu_result, alu_overflow,
      output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  alu_a, alu_b, alu_control,
      output alu_result, alu_overflow,
      input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err,
      output rsp_ready
   );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer names the favoured requester on a
// tie and moves away from whichever requester was just accepted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_valid,
   input  logic       i_accept,
   output logic [1:0] o_grant
);

   logic r_ptr;

   always_comb begin
      o_grant = i_valid;
      if (&i_valid) o_grant = r_ptr ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_ptr <= 1'b0;
      else if (i_accept) r_ptr <= o_grant[0];
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: IDLE grants, EXEC drives
// registered operands and captures the result, RESP holds the tagged response.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_arbiter_if.slave   bus
);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [OPW-1:0]   r_op;
   logic [OPW-1:0]   r_ctl;
   logic             r_id;
   logic [WIDTH-1:0] r_res;
   logic             r_ovf;
   logic             r_err;

   logic [1:0]       w_valid;
   logic [1:0]       w_grant;
   logic             w_idle;
   logic             w_accept;
   logic [OPW-1:0]   w_op;

   assign w_valid  = {bus.req1_valid, bus.req0_valid};
   assign w_idle   = (r_state == ST_IDLE);
   assign w_accept = w_idle && (|w_valid);
   assign w_op     = w_grant[1] ? bus.req1_op : bus.req0_op;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_valid  (w_valid),
      .i_accept (w_accept),
      .o_grant  (w_grant)
   );

   // Gated by rst_n so ready is also low while reset is held.
   assign bus.req0_ready = rst_n && w_idle && w_grant[0];
   assign bus.req1_ready = rst_n && w_idle && w_grant[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_ctl   <= '0;
         r_id    <= 1'b0;
         r_res   <= '0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a     <= w_grant[1] ? bus.req1_a : bus.req0_a;
                  r_b     <= w_grant[1] ? bus.req1_b : bus.req0_b;
                  r_op    <= w_op;
                  // Illegal codes never reach the ALU; it sees AND instead.
                  r_ctl   <= is_legal_op(w_op) ? w_op : OP_AND;
                  r_id    <= w_grant[1];
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_res   <= is_legal_op(r_op) ? bus.alu_result : '0;
               r_ovf   <= has_ovf(r_op) && bus.alu_overflow;
               r_err   <= !is_legal_op(r_op);
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.alu_a        = r_a;
   assign bus.alu_b        = r_b;
   assign bus.alu_control  = r_ctl;

   assign bus.rsp_valid    = (r_state == ST_RESP);
   assign bus.rsp_id       = r_id;
   assign bus.rsp_result   = r_res;
   assign bus.rsp_overflow = r_ovf;
   assign bus.rsp_err      = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed ops push expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic force_ovf = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(16), .OPW(4)) bus ();

   alu_arbiter #(.WIDTH(16), .OPW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference ALU: combinational from the DUT's ALU outputs.
   logic [15:0] m_add, m_sub;
   assign m_add = bus.alu_a + bus.alu_b;
   assign m_sub = bus.alu_a - bus.alu_b;

   always_comb begin
      bus.alu_result   = 16'hDEAD;
      bus.alu_overflow = 1'b1;
      case (bus.alu_control)
         OP_AND: begin bus.alu_result = bus.alu_a & bus.alu_b; bus.alu_overflow = force_ovf; end
         OP_OR:  begin bus.alu_result = bus.alu_a | bus.alu_b; bus.alu_overflow = force_ovf; end
         OP_ADD: begin
            bus.alu_result   = m_add;
            bus.alu_overflow = force_ovf | ((bus.alu_a[15] == bus.alu_b[15]) && (m_add[15] != bus.alu_a[15]));
         end
         OP_SUB: begin
            bus.alu_result   = m_sub;
            bus.alu_overflow = force_ovf | ((bus.alu_a[15] != bus.alu_b[15]) && (m_sub[15] != bus.alu_a[15]));
         end
         OP_SLT: begin
            bus.alu_result   = {15'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            bus.alu_overflow = force_ovf;
         end
         OP_NOR: begin bus.alu_result = ~(bus.alu_a | bus.alu_b); bus.alu_overflow = force_ovf; end
         default: ;
      endcase
   end

   a_req0_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req0_valid && !bus.req0_ready) |=> (!bus.req0_valid || $stable({bus.req0_a, bus.req0_b, bus.req0_op})));
   a_req1_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req1_valid && !bus.req1_ready) |=> (!bus.req1_valid || $stable({bus.req1_a, bus.req1_b, bus.req1_op})));

   typedef struct packed {
      logic        id;
      logic [15:0] res;
      logic        ovf;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic [15:0] res;
      logic        ovf;
   } op_t;

   exp_t sbq[$];
   exp_t m_e;
   op_t  tab0[4];
   op_t  tab1[4];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d result %h expected no response", bus.rsp_id, bus.rsp_result);
         end else begin
            m_e = sbq.pop_front();
            chk("rsp_id", 64'(bus.rsp_id), 64'(m_e.id));
            chk("rsp_result", 64'(bus.rsp_result), 64'(m_e.res));
            chk("rsp_overflow", 64'(bus.rsp_overflow), 64'(m_e.ovf));
            chk("rsp_err", 64'(bus.rsp_err), 64'(m_e.err));
         end
      end
   end

   task automatic drive(input bit rid, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op);
      if (rid == 1'b0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      end
   endtask

   function automatic logic rdy(input bit rid);
      return rid ? bus.req1_ready : bus.req0_ready;
   endfunction

   task automatic push_exp(input bit rid, input logic [15:0] res, input logic ovf, input logic err);
      exp_t e;
      e.id = rid; e.res = res; e.ovf = ovf; e.err = err;
      sbq.push_back(e);
   endtask

   // One op from one requester; checks EXEC-cycle ALU drive and N+2 rsp_valid.
   task automatic issue(input string name, input bit rid, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic [15:0] res, input logic ovf, input logic err,
                        output int waits);
      bit got = 1'b0;
      waits = 0;
      @(posedge clk); #1;
      drive(rid, 1'b1, a, b, op);
      while (!got && waits < 20) begin
         @(negedge clk);
         waits++;
         if (rdy(rid)) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_ready_timeout: got no ready expected ready within 20 cycles", name);
         drive(rid, 1'b0, '0, '0, '0);
         return;
      end
      push_exp(rid, res, ovf, err);
      @(posedge clk); #1;
      drive(rid, 1'b0, '0, '0, '0);
      @(negedge clk);
      chk({name, "_exec_a"}, 64'(bus.alu_a), 64'(a));
      chk({name, "_exec_b"}, 64'(bus.alu_b), 64'(b));
      chk({name, "_exec_ctl"}, 64'(bus.alu_control), 64'(err ? OP_AND : op));
      @(negedge clk);
      chk({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
   endtask

   // Both requesters valid continuously; grants must alternate starting at req0.
   task automatic run_both(input int n);
      int  i0 = 0, i1 = 0, g = 0, cyc = 0;
      logic gid;
      drive(1'b0, 1'b1, tab0[0].a, tab0[0].b, tab0[0].op);
      drive(1'b1, 1'b1, tab1[0].a, tab1[0].b, tab1[0].op);
      while ((i0 < n || i1 < n) && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.req0_ready && bus.req1_ready) chk("rr_onehot", 64'd3, 64'd1);
         if (bus.req0_ready || bus.req1_ready) begin
            gid = bus.req1_ready;
            chk("rr_grant", 64'(gid), 64'(g % 2));
            g++;
            if (gid == 1'b0) begin push_exp(1'b0, tab0[i0].res, tab0[i0].ovf, 1'b0); i0++; end
            else             begin push_exp(1'b1, tab1[i1].res, tab1[i1].ovf, 1'b0); i1++; end
         end
         @(posedge clk); #1;
         if (i0 < n) drive(1'b0, 1'b1, tab0[i0].a, tab0[i0].b, tab0[i0].op);
         else        drive(1'b0, 1'b0, '0, '0, '0);
         if (i1 < n) drive(1'b1, 1'b1, tab1[i1].a, tab1[i1].b, tab1[i1].op);
         else        drive(1'b1, 1'b0, '0, '0, '0);
      end
      chk("rr_all_granted", 64'(i0 + i1), 64'(2 * n));
      cyc = 0;
      while (sbq.size() != 0 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("rr_drained", 64'(sbq.size()), 64'd0);
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_overflow, bus.rsp_err,
                 bus.alu_a, bus.alu_b, bus.alu_control, bus.req0_ready, bus.req1_ready}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      int w;
      logic [18:0] held;
      tab0[0] = '{16'h0001, 16'h0002, OP_ADD, 16'h0003, 1'b0};
      tab0[1] = '{16'h00F0, 16'h0F00, OP_OR,  16'h0FF0, 1'b0};
      tab0[2] = '{16'hFFFF, 16'h0001, OP_SLT, 16'h0001, 1'b0};
      tab0[3] = '{16'h0F0F, 16'h00FF, OP_NOR, 16'hF000, 1'b0};
      tab1[0] = '{16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0};
      tab1[1] = '{16'hFF00, 16'h0FF0, OP_AND, 16'h0F00, 1'b0};
      tab1[2] = '{16'h8000, 16'h8000, OP_ADD, 16'h0000, 1'b1};
      tab1[3] = '{16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1};

      drive(1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, '0, '0, '0);
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset_outputs");
      @(posedge clk); #1 rst_n = 1'b1;

      issue("add0", 1'b0, 16'h0C35, 16'h00CA, OP_ADD, 16'h0CFF, 1'b0, 1'b0, w);
      chk("add0_ready_cycle", 64'(w), 64'd1);
      issue("sub1", 1'b1, 16'h0C35, 16'h00CA, OP_SUB, 16'h0B6B, 1'b0, 1'b0, w);
      issue("add_ovf", 1'b0, 16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b1, 1'b0, w);
      force_ovf = 1'b1;
      issue("and_ovfmask", 1'b1, 16'h0C35, 16'h00CA, OP_AND, 16'h0000, 1'b0, 1'b0, w);
      issue("illegal", 1'b0, 16'h1234, 16'h5678, 4'b0011, 16'h0000, 1'b0, 1'b1, w);
      force_ovf = 1'b0;
      issue("after_illegal", 1'b0, 16'h0003, 16'h0005, OP_OR, 16'h0007, 1'b0, 1'b0, w);

      // Backpressure: hold the response three cycles while req0 waits.
      @(posedge clk); #1 bus.rsp_ready = 1'b0;
      issue("bp", 1'b1, 16'h1111, 16'h2222, OP_ADD, 16'h3333, 1'b0, 1'b0, w);
      held = {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err};
      drive(1'b0, 1'b1, 16'h00AA, 16'h0055, OP_OR);
      repeat (3) begin
         @(negedge clk);
         chk("bp_rsp_hold", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err}), 64'(held));
         chk("bp_ovf_hold", 64'(bus.rsp_overflow), 64'd0);
         chk("bp_ready_low", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
      end
      @(posedge clk); #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_no_same_cycle_accept", 64'(bus.req0_ready), 64'd0);
      issue("bp_next", 1'b0, 16'h00AA, 16'h0055, OP_OR, 16'h00FF, 1'b0, 1'b0, w);
      chk("bp_next_ready_cycle", 64'(w), 64'd1);

      // Fresh reset, then both requesters contend for four ops each.
      @(posedge clk); #1 rst_n = 1'b0;
      sbq.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_both(4);

      // Async reset while an op is in EXEC: no response, pointer back to req0.
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 16'h0100, 16'h0200, OP_ADD);
      @(negedge clk);
      chk("mid_ready", 64'(bus.req0_ready), 64'd1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, '0, '0, '0);
      chk("mid_exec_a", 64'(bus.alu_a), 64'h0100);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("mid_reset_async");
      sbq.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
      end
      @(posedge clk); #1;
      run_both(1);

      repeat (5) @(negedge clk);
      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester round-robin controller that shares one 16-bit ALU. Each requester presents operands and a 4-bit op on a valid/ready channel. The block grants one request at a time and drives the external ALU's A/B/control inputs from registered operands. It captures the ALU's result and overflow, then returns them on a shared response channel tagged with the requester ID. It sits between issue logic and the ALU and is the only driver of the ALU inputs.

Parameters:
WIDTH, 16, operand/result width
OPW, 4, ALU control width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req0_op  in  OPW  ALU control code
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_control  out  OPW  to ALU control
alu_result  in  WIDTH  ALU result, combinational from alu_* inputs
alu_overflow  in  1  ALU overflow
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the op
rsp_result  out  WIDTH  captured result
rsp_overflow  out  1  overflow, masked as below
rsp_err  out  1  illegal op code

Behaviour:
- Legal ops (package constants): AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100. Every other code is illegal.
- FSM states and transitions:
  - IDLE: if any req valid, grant one; -> EXEC.
  - EXEC: one cycle, ALU inputs stable; capture result; -> RESP.
  - RESP: rsp_valid=1; on rsp_ready -> IDLE.
- Grant in IDLE:
  - req_ready is combinational: high only in IDLE and only for the granted requester.
  - Accept = valid && ready. On accept, a/b/op/id are registered.
- Round-robin pointer:
  - Reset value favours requester 0.
  - If both requesters are valid, the pointer side wins.
  - After every accept, the pointer moves to the other requester.
  - If only one requester is valid, it is granted regardless of the pointer; the pointer still toggles away from the winner.
- alu_a/alu_b/alu_control are driven from the operand registers. They reset to 0 and hold their last value outside EXEC.
- Illegal op:
  - alu_control is forced to AND (0000) during EXEC.
  - rsp_result=0, rsp_overflow=0, rsp_err=1.
- rsp_overflow = alu_overflow only for ADD/SUB; 0 for all other ops.
- Latency: accept at cycle N (IDLE); EXEC at N+1; rsp_valid from N+2. Minimum 3 cycles per op, so peak throughput is 1 op per 3 cycles.
- Backpressure:
  - While rsp_valid && !rsp_ready, all rsp_* outputs are held stable and both req_ready stay 0.
  - New requests are not accepted in the cycle rsp_ready is seen. The next accept is at the earliest one cycle later, in IDLE.
- Requester rules (bench checks them with assertions):
  - A requester must hold a/b/op stable while valid && !ready.
  - A requester may drop valid without handshake; the block tolerates it.
- Reset (async, any time):
  - State -> IDLE; all outputs 0 (rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err, alu_*, req_ready); pointer -> requester 0.
  - An in-flight op is discarded with no response.
- Simultaneous events: a requester that asserts valid during EXEC or RESP waits. It is arbitrated in the next IDLE cycle.

Decomposition:
- Package alu_pkg holds:
  - Op code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR).
  - A function is_legal_op(op).
  - FSM state encoding (ST_IDLE, ST_EXEC, ST_RESP).
- One natural sub-module: rr_arb2. It is a 2-way round-robin grant with pointer register, inputs valid[1:0] and accept, output grant one-hot.

Test Plan:
- After reset, req0 ADD a=0x0C35 b=0x00CA, rsp_ready=1 -> req0_ready at cycle 1; alu_a=0x0C35/alu_control=0010 in EXEC; rsp_valid at N+2 with id=0, result=0x0CFF, ovf=0, err=0.
- req1 SUB 0x0C35-0x00CA -> result 0x0B6B, id=1. ADD 0x7FFF+0x0001 -> result 0x8000, ovf=1. AND 0x0C35&0x00CA -> 0x0000, ovf=0 even if the ALU model asserts overflow.
- Both requesters valid continuously from reset, 4 ops each -> grants alternate 0,1,0,1…; rsp_id sequence matches; no starvation.
- Illegal op 0011 from req0 -> alu_control=0000 in EXEC; rsp_err=1, result=0x0000, ovf=0; the next legal op completes normally.
- rsp_ready low 3 cycles during RESP -> rsp_* values stable; req0/1_ready stay 0; the response completes on the first rsp_ready=1 cycle.
- rst_n pulsed low mid-EXEC -> outputs 0 immediately (async); no response emitted; the first post-reset grant goes to req0 when both are valid.
